// File: rtl/sm4_encryptor_pkg.sv
// Shared widths, chaining-mode states and a small XOR helper for the SM4 mode front end.
// The encryptor uses the same widths, so both sides agree on word and group sizes.
package sm4_encryptor_pkg;

    localparam int word_width_p      = 32;
    localparam int group_size_p      = 128;
    localparam int words_per_group_p = group_size_p / word_width_p;

    typedef enum logic [2:0] {
        eIdle    = 3'd0,
        eCollect = 3'd1,
        eIssue   = 3'd2,
        eWait    = 3'd3,
        eOut     = 3'd4
    } mode_state_e;

    // Conditionally fold a chain value into a group; passes 'a' through when disabled.
    function automatic logic [group_size_p-1:0] xor_if(
        input logic                    en,
        input logic [group_size_p-1:0] a,
        input logic [group_size_p-1:0] b
    );
        return en ? (a ^ b) : a;
    endfunction

endpackage

// File: rtl/sm4_word_packer.sv
// Packs four stream words into one group, oldest word in the top slice.
// full_o flags the cycle in which the fourth word is being shifted in.
module sm4_word_packer
    import sm4_encryptor_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    shift_i,
    input  logic [word_width_p-1:0] word_i,
    output logic [group_size_p-1:0] blk_o,
    output logic [1:0]              count_o,
    output logic                    full_o
);

    logic [group_size_p-1:0] r_blk;
    logic [1:0]              r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_blk   <= '0;
            r_count <= 2'd0;
        end else if (shift_i) begin
            r_blk   <= {r_blk[group_size_p-word_width_p-1:0], word_i};
            r_count <= r_count + 2'd1;
        end
    end

    assign blk_o   = r_blk;
    assign count_o = r_count;
    assign full_o  = shift_i && (r_count == 2'd3);

endmodule

// File: rtl/sm4_mode_ctrl.sv
// ECB/CBC chaining front end for sm4_encryptor: packs words, applies the chain XOR,
// drives the encryptor handshake and holds each result on a valid/yumi output.
module sm4_mode_ctrl
    import sm4_encryptor_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         cbc_i,
    input  logic         decode_i,
    input  logic         stop_i,
    input  logic [31:0]  word_i,
    input  logic         word_v_i,
    output logic         word_ready_o,
    output logic [127:0] enc_content_o,
    output logic [127:0] enc_key_o,
    output logic         enc_decode_o,
    output logic         enc_v_o,
    input  logic         enc_ready_i,
    input  logic [127:0] enc_crypt_i,
    input  logic         enc_v_i,
    output logic         enc_yumi_o,
    output logic [127:0] data_o,
    output logic         v_o,
    input  logic         yumi_i,
    output logic         busy_o,
    output logic [2:0]   state_o
);

    // Handshakes: a transfer happens in the cycle where valid and ready (or v and yumi)
    // are both high; a valid never drops before its transfer, and data is stable while valid.

    mode_state_e r_state;
    mode_state_e w_state_nxt;

    logic [group_size_p-1:0] r_key;
    logic [group_size_p-1:0] r_chain;
    logic [group_size_p-1:0] r_data;
    logic                    r_cbc;
    logic                    r_dec;

    logic [group_size_p-1:0] w_blk;
    logic [group_size_p-1:0] w_result;
    logic [1:0]              w_count;
    logic                    w_full;
    logic                    w_shift;
    logic                    w_stop;
    logic                    w_start_ok;
    logic                    w_capture;

    // A stop at a group boundary takes priority, so the word offered alongside it is refused.
    assign w_stop       = stop_i && (w_count == 2'd0);
    assign word_ready_o = (r_state == eCollect) && !w_stop;
    assign w_shift      = word_v_i && word_ready_o;

    sm4_word_packer u_packer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_start_ok),
        .shift_i (w_shift),
        .word_i  (word_i),
        .blk_o   (w_blk),
        .count_o (w_count),
        .full_o  (w_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        enc_v_o     = 1'b0;
        enc_yumi_o  = 1'b0;
        v_o         = 1'b0;
        w_start_ok  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            eIdle: begin
                if (start_i) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = eCollect;
                end
            end
            eCollect: begin
                if (w_stop) begin
                    w_state_nxt = eIdle;
                end else if (w_full) begin
                    w_state_nxt = eIssue;
                end
            end
            eIssue: begin
                enc_v_o = 1'b1;
                if (enc_ready_i) begin
                    w_state_nxt = eWait;
                end
            end
            eWait: begin
                if (enc_v_i) begin
                    enc_yumi_o  = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = eOut;
                end
            end
            eOut: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    w_state_nxt = eCollect;
                end
            end
            default: begin
                w_state_nxt = eIdle;
            end
        endcase
    end

    // CBC decrypt removes the previous ciphertext after the block cipher.
    assign w_result = xor_if(r_cbc && r_dec, enc_crypt_i, r_chain);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIdle;
            r_key   <= '0;
            r_chain <= '0;
            r_data  <= '0;
            r_cbc   <= 1'b0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_key   <= key_i;
                r_chain <= iv_i;
                r_cbc   <= cbc_i;
                r_dec   <= decode_i;
            end
            if (w_capture) begin
                r_data <= w_result;
                if (r_cbc) begin
                    r_chain <= r_dec ? w_blk : enc_crypt_i;
                end
            end
        end
    end

    // The packed group is frozen from eIssue to capture, so the content stays stable.
    assign enc_content_o = xor_if(r_cbc && !r_dec, w_blk, r_chain);
    assign enc_key_o     = r_key;
    assign enc_decode_o  = r_dec;
    assign data_o        = r_data;
    assign busy_o        = (r_state != eIdle);
    assign state_o       = r_state;

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Directed bench for sm4_mode_ctrl with a behavioural encryptor stand-in that knows
// the SM4 reference vector and uses a self-inverse toy transform for all other content.
module tb_sm4_mode_ctrl;

    localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] P  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C1 = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] M  = 128'hA5A5_0F0F_3C3C_5A5A_C3C3_F0F0_9696_6969;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] iv_i = '0;
    logic         cbc_i = 1'b0;
    logic         decode_i = 1'b0;
    logic         stop_i = 1'b0;
    logic [31:0]  word_i = '0;
    logic         word_v_i = 1'b0;
    logic         word_ready_o;
    logic [127:0] enc_content_o;
    logic [127:0] enc_key_o;
    logic         enc_decode_o;
    logic         enc_v_o;
    logic         enc_ready_i;
    logic [127:0] enc_crypt_i;
    logic         enc_v_i;
    logic         enc_yumi_o;
    logic [127:0] data_o;
    logic         v_o;
    logic         yumi_i = 1'b0;
    logic         busy_o;
    logic [2:0]   state_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sm4_mode_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .key_i         (key_i),
        .iv_i          (iv_i),
        .cbc_i         (cbc_i),
        .decode_i      (decode_i),
        .stop_i        (stop_i),
        .word_i        (word_i),
        .word_v_i      (word_v_i),
        .word_ready_o  (word_ready_o),
        .enc_content_o (enc_content_o),
        .enc_key_o     (enc_key_o),
        .enc_decode_o  (enc_decode_o),
        .enc_v_o       (enc_v_o),
        .enc_ready_i   (enc_ready_i),
        .enc_crypt_i   (enc_crypt_i),
        .enc_v_i       (enc_v_i),
        .enc_yumi_o    (enc_yumi_o),
        .data_o        (data_o),
        .v_o           (v_o),
        .yumi_i        (yumi_i),
        .busy_o        (busy_o),
        .state_o       (state_o)
    );

    // ---------------- encryptor stand-in ----------------
    function automatic logic [127:0] toy_cipher(input logic [127:0] x, input logic [127:0] k,
                                                input logic dec);
        if (!dec && x == P && k == K) return C1;
        if (dec && x == C1 && k == K) return P;
        return x ^ {k[63:0], k[127:64]} ^ M;
    endfunction

    logic         st_busy, st_v, st_dec;
    logic [1:0]   st_cnt;
    logic [127:0] st_in, st_key, st_out;

    assign enc_ready_i = ~st_busy;
    assign enc_v_i     = st_v;
    assign enc_crypt_i = st_out;

    always @(posedge clk) begin
        if (reset_i) begin
            st_busy <= 1'b0;
            st_v    <= 1'b0;
            st_cnt  <= 2'd0;
            st_out  <= '0;
            st_in   <= '0;
            st_key  <= '0;
            st_dec  <= 1'b0;
        end else if (!st_busy && enc_v_o) begin
            st_busy <= 1'b1;
            st_in   <= enc_content_o;
            st_key  <= enc_key_o;
            st_dec  <= enc_decode_o;
            st_cnt  <= 2'd3;
        end else if (st_busy && !st_v) begin
            if (st_cnt == 2'd0) begin
                st_v   <= 1'b1;
                st_out <= toy_cipher(st_in, st_key, st_dec);
            end else begin
                st_cnt <= st_cnt - 2'd1;
            end
        end else if (st_v && enc_yumi_o) begin
            st_v    <= 1'b0;
            st_busy <= 1'b0;
        end
    end

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic do_start(input logic [127:0] k, input logic [127:0] iv,
                            input logic cbc, input logic dec);
        key_i = k; iv_i = iv; cbc_i = cbc; decode_i = dec; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output logic ok);
        ok = 1'b0;
        word_i = w;
        word_v_i = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (word_ready_o) ok = 1'b1;
            @(negedge clk);
        end
        word_v_i = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, output logic ok);
        logic w_ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(blk[127-32*i -: 32], w_ok);
            ok = ok & w_ok;
        end
    endtask

    // Waits for the encryptor result handshake; v_next is v_o one cycle after it.
    task automatic wait_result(output logic ok, output logic v_next);
        ok = 1'b0;
        v_next = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (enc_yumi_o) begin
                ok = 1'b1;
                @(negedge clk);
                v_next = v_o;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic take_output();
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
    endtask

    task automatic end_session();
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        tests++;
        if ({word_ready_o, enc_v_o, enc_yumi_o, v_o, busy_o, enc_decode_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {word_ready_o, enc_v_o, enc_yumi_o, v_o, busy_o, enc_decode_o});
        end
        tests++;
        if ({data_o, enc_content_o, enc_key_o} !== 384'b0) begin
            fails++;
            $display("FAIL reset_data: data %h content %h key %h want 0", data_o, enc_content_o, enc_key_o);
        end
        tests++;
        if (state_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d want 0", state_o);
        end
    endtask

    task automatic test_ecb_encrypt();
        logic ok, vn;
        do_start(K, '0, 1'b0, 1'b0);
        tests++;
        if (busy_o !== 1'b1 || word_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ecb_enc_start: busy %b ready %b want 1 1", busy_o, word_ready_o);
        end
        send_block(P, ok);
        tests++;
        if (!ok || enc_v_o !== 1'b1) begin
            fails++;
            $display("FAIL ecb_enc_issue_timing: accepted %b enc_v %b want 1 1", ok, enc_v_o);
        end
        tests++;
        if (enc_content_o !== P || enc_key_o !== K || enc_decode_o !== 1'b0) begin
            fails++;
            $display("FAIL ecb_enc_to_cipher: content %h key %h dec %b", enc_content_o, enc_key_o, enc_decode_o);
        end
        tests++;
        if (word_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL ecb_enc_no_words: ready %b want 0", word_ready_o);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || vn !== 1'b1) begin
            fails++;
            $display("FAIL ecb_enc_out_timing: seen %b v_o %b want 1 1", ok, vn);
        end
        tests++;
        if (data_o !== C1) begin
            fails++;
            $display("FAIL ecb_enc_data: got %h want %h", data_o, C1);
        end
        take_output();
        tests++;
        if (v_o !== 1'b0 || word_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ecb_enc_release: v %b ready %b want 0 1", v_o, word_ready_o);
        end
        end_session();
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL ecb_enc_stop: busy %b want 0", busy_o);
        end
    endtask

    task automatic test_ecb_decrypt();
        logic ok, vn;
        do_start(K, '0, 1'b0, 1'b1);
        send_block(C1, ok);
        tests++;
        if (!ok || enc_content_o !== C1 || enc_decode_o !== 1'b1) begin
            fails++;
            $display("FAIL ecb_dec_to_cipher: content %h dec %b want %h 1", enc_content_o, enc_decode_o, C1);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || data_o !== P) begin
            fails++;
            $display("FAIL ecb_dec_data: got %h want %h", data_o, P);
        end
        take_output();
        end_session();
    endtask

    task automatic test_cbc_encrypt();
        logic ok, vn;
        logic [127:0] c2;
        c2 = (P ^ C1) ^ {K[63:0], K[127:64]} ^ M;
        do_start(K, '0, 1'b1, 1'b0);
        send_block(P, ok);
        tests++;
        if (!ok || enc_content_o !== P) begin
            fails++;
            $display("FAIL cbc_enc_content1: got %h want %h", enc_content_o, P);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || data_o !== C1) begin
            fails++;
            $display("FAIL cbc_enc_data1: got %h want %h", data_o, C1);
        end
        take_output();
        send_block(P, ok);
        tests++;
        if (!ok || enc_content_o !== (P ^ C1)) begin
            fails++;
            $display("FAIL cbc_enc_content2: got %h want %h", enc_content_o, P ^ C1);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || data_o !== c2) begin
            fails++;
            $display("FAIL cbc_enc_data2: got %h want %h", data_o, c2);
        end
        take_output();
        end_session();
    endtask

    task automatic test_cbc_decrypt();
        logic ok, vn;
        logic [127:0] c2;
        c2 = (P ^ C1) ^ {K[63:0], K[127:64]} ^ M;
        do_start(K, '0, 1'b1, 1'b1);
        send_block(C1, ok);
        tests++;
        if (!ok || enc_content_o !== C1) begin
            fails++;
            $display("FAIL cbc_dec_content1: got %h want %h", enc_content_o, C1);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || data_o !== P) begin
            fails++;
            $display("FAIL cbc_dec_data1: got %h want %h", data_o, P);
        end
        take_output();
        send_block(c2, ok);
        tests++;
        if (!ok || enc_content_o !== c2) begin
            fails++;
            $display("FAIL cbc_dec_content2: got %h want %h", enc_content_o, c2);
        end
        wait_result(ok, vn);
        tests++;
        if (!ok || data_o !== P) begin
            fails++;
            $display("FAIL cbc_dec_data2: got %h want %h", data_o, P);
        end
        take_output();
        end_session();
    endtask

    task automatic test_backpressure();
        logic ok, vn;
        do_start(K, '0, 1'b0, 1'b0);
        send_block(P, ok);
        wait_result(ok, vn);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_result: encryptor result not seen");
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (data_o !== C1 || v_o !== 1'b1 || word_ready_o !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: data %h v %b ready %b", i, data_o, v_o, word_ready_o);
            end
            @(negedge clk);
        end
        yumi_i = 1'b1;
        #1;
        tests++;
        if (word_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_same_cycle: got %b want 0", word_ready_o);
        end
        @(negedge clk);
        yumi_i = 1'b0;
        tests++;
        if (word_ready_o !== 1'b1 || v_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_after: ready %b v %b want 1 0", word_ready_o, v_o);
        end
        // Stray yumi and a start while busy must both be ignored.
        yumi_i = 1'b1;
        do_start(~K, '1, 1'b1, 1'b1);
        yumi_i = 1'b0;
        tests++;
        if (v_o !== 1'b0 || enc_key_o !== K || enc_decode_o !== 1'b0 || state_o !== 3'd1) begin
            fails++;
            $display("FAIL bp_ignored: v %b key %h dec %b state %0d", v_o, enc_key_o, enc_decode_o, state_o);
        end
        end_session();
    endtask

    task automatic test_stop_edge();
        do_start(K, '0, 1'b0, 1'b0);
        stop_i = 1'b1;
        word_v_i = 1'b1;
        word_i = 32'hdeadbeef;
        #1;
        tests++;
        if (word_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL stop_refuses_word: ready %b want 0", word_ready_o);
        end
        @(negedge clk);
        stop_i = 1'b0;
        word_v_i = 1'b0;
        tests++;
        if (busy_o !== 1'b0 || state_o !== 3'd0) begin
            fails++;
            $display("FAIL stop_to_idle: busy %b state %0d want 0 0", busy_o, state_o);
        end
    endtask

    task automatic test_reset_mid();
        logic ok, seen;
        do_start(K, '0, 1'b1, 1'b0);
        send_block(P, ok);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (state_o == 3'd3) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_mid_reach_wait: state %0d want 3", state_o);
        end
        reset_i = 1'b1;
        @(negedge clk);
        tests++;
        if ({word_ready_o, enc_v_o, enc_yumi_o, v_o, busy_o, enc_decode_o} !== 6'b0 ||
            {data_o, enc_content_o, enc_key_o} !== 384'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: ctrl %b data %h content %h key %h want 0",
                     {word_ready_o, enc_v_o, enc_yumi_o, v_o, busy_o, enc_decode_o},
                     data_o, enc_content_o, enc_key_o);
        end
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ecb_encrypt();
        test_ecb_decrypt();
        test_cbc_encrypt();
        test_cbc_decrypt();
        test_backpressure();
        test_stop_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
